// File: rtl/vga_fb_arbiter.sv
// Frame-buffer BRAM arbiter with double-buffered pages and a small host write FIFO.
// BRAM access issues one cycle after request; VGA never stalls, host sees backpressure only when the FIFO is full.

// Generic FIFO: the head entry is visible combinationally and pushes/pops land on the next edge.
// Pushes while full and pops while empty are ignored.
module vga_fb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// Arbiter top: VGA reads win the single BRAM port, host writes drain on free cycles, pages flip at vsync.
// Read data returns two cycles after the VGA request; host_wready_o is low only while the FIFO is full or in reset.
module vga_fb_arbiter #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                FIFO_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] PAGE_OFFSET = ADDR_W'(32'h12C00)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] vga_bram_addr_i,
    input  logic              vga_bram_en_i,
    input  logic              vga_vsync_i,
    output logic [DATA_W-1:0] vga_rdata_o,
    input  logic              host_wvalid_i,
    output logic              host_wready_o,
    input  logic [ADDR_W-1:0] host_waddr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    input  logic              flip_req_i,
    output logic              flip_pending_o,
    output logic              front_page_o,
    output logic              drop_err_o,
    output logic              bram_en_o,
    output logic              bram_we_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [DATA_W-1:0] bram_din_o,
    input  logic [DATA_W-1:0] bram_dout_i
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    typedef enum logic [1:0] {
        G_IDLE = 2'b00,
        G_VGA  = 2'b01,
        G_HOST = 2'b11
    } grant_e;

    grant_e            gnt_q;
    grant_e            gnt_d;
    logic [ADDR_W-1:0] bram_addr_q;
    logic [ADDR_W-1:0] bram_addr_d;
    logic [DATA_W-1:0] bram_din_q;
    logic [DATA_W-1:0] bram_din_d;
    logic              front_page_q;
    logic              front_page_d;
    logic              flip_pending_q;
    logic              flip_pending_d;
    logic              drop_err_q;
    logic              drop_err_d;
    logic              vsync_q;

    logic [ADDR_W-1:0] front_base;
    logic [ADDR_W-1:0] back_base;
    logic              host_hs;
    logic              host_in_range;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    wr_entry_t         push_entry;
    wr_entry_t         head_entry;
    logic              vsync_rise;
    logic              drained;
    logic              flip_fire;

    assign front_base = front_page_q ? PAGE_OFFSET : '0;
    assign back_base  = front_page_q ? '0 : PAGE_OFFSET;

    // Out-of-range writes still complete the handshake so the host never deadlocks on them.
    assign host_wready_o = ~fifo_full & ~reset_i;
    assign host_hs       = host_wvalid_i & host_wready_o;
    assign host_in_range = (host_waddr_i < PAGE_OFFSET);
    assign fifo_push     = host_hs & host_in_range;
    assign push_entry    = '{addr: host_waddr_i + back_base, data: host_wdata_i};

    vga_fb_fifo #(
        .WIDTH ($bits(wr_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk_i   (clk_i),
        .rst_i   (reset_i),
        .push_i  (fifo_push),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            gnt_q       <= G_IDLE;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
        end else begin
            gnt_q       <= gnt_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
        end
    end

    always_comb begin
        gnt_d = G_IDLE;
        if (vga_bram_en_i) begin
            gnt_d = G_VGA;
        end else if (!fifo_empty) begin
            gnt_d = G_HOST;
        end
    end

    always_comb begin
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        fifo_pop    = 1'b0;
        case (gnt_d)
            G_VGA: begin
                bram_addr_d = vga_bram_addr_i + front_base;
            end
            G_HOST: begin
                bram_addr_d = head_entry.addr;
                bram_din_d  = head_entry.data;
                fifo_pop    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bram_en_o   = (gnt_q != G_IDLE);
    assign bram_we_o   = (gnt_q == G_HOST);
    assign bram_addr_o = bram_addr_q;
    assign bram_din_o  = bram_din_q;
    assign vga_rdata_o = bram_dout_i;

    // Flip only once every queued write has left, so none lands on the page about to be shown.
    assign vsync_rise     = vga_vsync_i & ~vsync_q;
    assign drained        = fifo_empty | (fifo_pop & (fifo_count == CNT_W'(1)));
    assign flip_fire      = vsync_rise & flip_pending_q & drained;
    assign front_page_d   = front_page_q ^ flip_fire;
    assign flip_pending_d = ~flip_fire & (flip_pending_q | flip_req_i);
    assign drop_err_d     = drop_err_q | (host_hs & ~host_in_range);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            front_page_q   <= 1'b0;
            flip_pending_q <= 1'b0;
            drop_err_q     <= 1'b0;
            vsync_q        <= 1'b0;
        end else begin
            front_page_q   <= front_page_d;
            flip_pending_q <= flip_pending_d;
            drop_err_q     <= drop_err_d;
            vsync_q        <= vga_vsync_i;
        end
    end

    assign front_page_o   = front_page_q;
    assign flip_pending_o = flip_pending_q;
    assign drop_err_o     = drop_err_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a queue-based behavioural model and a simple BRAM memory model.
module tb_vga_fb_arbiter;
    localparam logic [31:0] OFF   = 32'h12C00;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] vga_bram_addr;
    logic        vga_bram_en;
    logic        vga_vsync;
    logic [31:0] vga_rdata;
    logic        host_wvalid;
    logic        host_wready;
    logic [31:0] host_waddr;
    logic [31:0] host_wdata;
    logic        flip_req;
    logic        flip_pending;
    logic        front_page;
    logic        drop_err;
    logic        bram_en;
    logic        bram_we;
    logic [31:0] bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;
    int ph;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .FIFO_DEPTH  (DEPTH),
        .PAGE_OFFSET (OFF)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .vga_bram_addr_i (vga_bram_addr),
        .vga_bram_en_i   (vga_bram_en),
        .vga_vsync_i     (vga_vsync),
        .vga_rdata_o     (vga_rdata),
        .host_wvalid_i   (host_wvalid),
        .host_wready_o   (host_wready),
        .host_waddr_i    (host_waddr),
        .host_wdata_i    (host_wdata),
        .flip_req_i      (flip_req),
        .flip_pending_o  (flip_pending),
        .front_page_o    (front_page),
        .drop_err_o      (drop_err),
        .bram_en_o       (bram_en),
        .bram_we_o       (bram_we),
        .bram_addr_o     (bram_addr),
        .bram_din_o      (bram_din),
        .bram_dout_i     (bram_dout)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
    endfunction

    // Single-port BRAM with one-cycle read latency; contents survive reset.
    logic [31:0] bmem [logic [31:0]];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) bmem[bram_addr] = bram_din;
            else bram_dout <= bmem.exists(bram_addr) ? bmem[bram_addr] : init_val(bram_addr);
        end
    end

    // Behavioural model: queue of pending physical writes plus page/flag state.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         q[$];
    wr_t         e;
    logic [31:0] mmem [logic [31:0]];
    logic        m_en = 0, m_we = 0, m_front = 0, m_pend = 0, m_drop = 0, m_vs = 0;
    logic [31:0] m_addr = 0, m_din = 0;
    logic        w_pend = 0;
    logic [31:0] w_a = 0, w_d = 0;
    logic        r_v0 = 0, r_v1 = 0;
    logic [31:0] r_d0 = 0, r_d1 = 0;
    logic        m_hs, m_rise, m_fire;

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            m_en = 0; m_we = 0; m_addr = 0; m_din = 0;
            m_front = 0; m_pend = 0; m_drop = 0; m_vs = 0;
            w_pend = 0; r_v0 = 0; r_v1 = 0;
        end else if (w_pend) begin
            mmem[w_a] = w_d;
            w_pend = 0;
        end
        chk("m_bram_en", bram_en, m_en);
        chk("m_bram_we", bram_we, m_we);
        chk("m_bram_addr", bram_addr, m_addr);
        chk("m_bram_din", bram_din, m_din);
        chk("m_front_page", front_page, m_front);
        chk("m_flip_pending", flip_pending, m_pend);
        chk("m_drop_err", drop_err, m_drop);
        chk("m_host_wready", host_wready, !reset && q.size() < DEPTH);
        if (r_v1) chk("m_vga_rdata", vga_rdata, r_d1);
        if (!reset) begin
            r_v1 = r_v0; r_d1 = r_d0; r_v0 = 0;
            m_hs = host_wvalid && (q.size() < DEPTH);
            if (vga_bram_en) begin
                m_en = 1; m_we = 0;
                m_addr = vga_bram_addr + (m_front ? OFF : 32'd0);
                r_v0 = 1;
                r_d0 = mmem.exists(m_addr) ? mmem[m_addr] : init_val(m_addr);
            end else if (q.size() != 0) begin
                e = q.pop_front();
                m_en = 1; m_we = 1; m_addr = e.a; m_din = e.d;
                w_pend = 1; w_a = e.a; w_d = e.d;
            end else begin
                m_en = 0; m_we = 0;
            end
            m_rise = vga_vsync && !m_vs;
            m_vs   = vga_vsync;
            m_fire = m_rise && m_pend && (q.size() == 0);
            if (m_hs) begin
                if (host_waddr < OFF) q.push_back('{host_waddr + (m_front ? 32'd0 : OFF), host_wdata});
                else m_drop = 1;
            end
            if (m_fire) begin
                m_front = !m_front;
                m_pend  = 0;
            end else if (flip_req) begin
                m_pend = 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; vga_bram_en = 0; vga_bram_addr = 0; vga_vsync = 0;
        host_wvalid = 0; host_waddr = 0; host_wdata = 0; flip_req = 0;
        cyc(); cyc();
        chk("rst_bram_en", bram_en, 0);
        chk("rst_bram_we", bram_we, 0);
        chk("rst_bram_addr", bram_addr, 0);
        chk("rst_bram_din", bram_din, 0);
        chk("rst_front", front_page, 0);
        chk("rst_pending", flip_pending, 0);
        chk("rst_drop", drop_err, 0);
        chk("rst_wready_low", host_wready, 0);
        reset = 0;
        cyc();
        chk("wready_after_rst", host_wready, 1);

        vga_bram_en = 1;
        for (int i = 5; i < 8; i++) begin
            vga_bram_addr = i;
            cyc();
            chk("vga_addr", bram_addr, i);
            chk("vga_we", bram_we, 0);
        end

        vga_bram_addr = 100;
        for (int i = 0; i < 4; i++) begin
            host_wvalid = 1; host_waddr = i; host_wdata = 32'hA0 + i;
            cyc();
            chk("fill_no_write", bram_we, 0);
        end
        host_wvalid = 0;
        chk("full_wready", host_wready, 0);
        vga_bram_en = 0; host_wvalid = 1; host_waddr = 9; host_wdata = 32'h99;
        for (int i = 0; i < 4; i++) begin
            cyc();
            host_wvalid = 0;
            chk("drain_we", bram_we, 1);
            chk("drain_addr", bram_addr, OFF + i);
            chk("drain_din", bram_din, 32'hA0 + i);
        end
        cyc();
        chk("full_no_push", bram_en, 0);

        vga_bram_en = 1; vga_bram_addr = 3; host_wvalid = 1; host_waddr = 20; host_wdata = 32'h55;
        cyc();
        host_wvalid = 0;
        cyc();
        chk("prio_vga_we", bram_we, 0);
        chk("prio_vga_addr", bram_addr, 3);
        vga_bram_en = 0;
        cyc();
        chk("prio_host_we", bram_we, 1);
        chk("prio_host_addr", bram_addr, OFF + 20);

        flip_req = 1;
        cyc();
        flip_req = 0;
        chk("flip_pending_set", flip_pending, 1);
        chk("front_before_rise", front_page, 0);
        vga_vsync = 1;
        cyc();
        chk("front_after_rise", front_page, 1);
        chk("pending_cleared", flip_pending, 0);
        vga_vsync = 0; vga_bram_en = 1; vga_bram_addr = 0;
        cyc();
        chk("flip_vga_addr", bram_addr, OFF);
        vga_bram_en = 0; host_wvalid = 1; host_waddr = 0; host_wdata = 32'h77;
        cyc();
        host_wvalid = 0;
        cyc();
        chk("flip_host_we", bram_we, 1);
        chk("flip_host_addr", bram_addr, 0);

        vga_bram_en = 1; vga_bram_addr = 1; flip_req = 1;
        cyc();
        flip_req = 0; host_wvalid = 1; host_waddr = 1; host_wdata = 32'h11;
        cyc();
        host_waddr = 2; host_wdata = 32'h22;
        cyc();
        host_wvalid = 0; vga_vsync = 1;
        cyc();
        chk("busy_no_flip", front_page, 1);
        chk("busy_still_pending", flip_pending, 1);
        vga_bram_en = 0;
        cyc();
        chk("drain_backpage", bram_addr, 1);
        cyc();
        vga_vsync = 0;
        cyc();
        vga_vsync = 1;
        cyc();
        vga_vsync = 0;
        chk("late_flip_front", front_page, 0);
        chk("late_flip_pending", flip_pending, 0);

        host_wvalid = 1; host_waddr = OFF; host_wdata = 32'hDD;
        chk("drop_hs_ready", host_wready, 1);
        cyc();
        host_wvalid = 0;
        chk("drop_no_write", bram_en, 0);
        chk("drop_err_set", drop_err, 1);
        cyc();
        chk("drop_no_write2", bram_en, 0);
        repeat (3) cyc();
        chk("drop_sticky", drop_err, 1);

        vga_bram_en = 1; vga_bram_addr = 33; host_wvalid = 1;
        for (int i = 0; i < 3; i++) begin
            host_waddr = 40 + i; host_wdata = 32'hE0 + i;
            cyc();
        end
        host_wvalid = 0;
        reset = 1;
        #1;
        chk("arst_en", bram_en, 0);
        chk("arst_we", bram_we, 0);
        chk("arst_addr", bram_addr, 0);
        chk("arst_din", bram_din, 0);
        chk("arst_drop", drop_err, 0);
        chk("arst_pending", flip_pending, 0);
        chk("arst_wready", host_wready, 0);
        cyc();
        reset = 0; vga_bram_en = 0;
        cyc();
        chk("arst_fifo_empty", bram_en, 0);
        cyc();
        chk("arst_fifo_empty2", bram_en, 0);

        for (int c = 0; c < 4000; c++) begin
            ph = c % 48;
            vga_vsync   = (ph >= 40 && ph < 43);
            vga_bram_en = (ph >= 36) ? 1'b0 : ($urandom_range(9) < 7);
            vga_bram_addr = ($urandom_range(19) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15)
                                                      : $urandom_range(63);
            host_wvalid = $urandom_range(1);
            host_waddr  = ($urandom_range(29) == 0) ? OFF + $urandom_range(3) : $urandom_range(63);
            host_wdata  = $urandom;
            flip_req    = ($urandom_range(24) == 0);
            reset       = (c > 100) && ($urandom_range(999) == 0);
            cyc();
        end
        reset = 0; vga_bram_en = 0; host_wvalid = 0; flip_req = 0; vga_vsync = 0;
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
